// File: rtl/vga_textram_pkg.sv
// Shared definitions for the text-mode character RAM: fill-engine state encoding and default screen geometry.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package vga_textram_pkg;

  // Default geometry: 80x30 cells of {4-bit attr, 7-bit char}.
  localparam int unsigned DEF_N_COLS = 80;
  localparam int unsigned DEF_N_ROWS = 30;
  localparam int unsigned DEF_CHAR_W = 7;
  localparam int unsigned DEF_ATTR_W = 4;
  localparam int unsigned DEF_ADDR_W = 12;

  // Fill-engine states: idle, whole-screen clear, single-row blank after scroll.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SCROLL = 2'd2
  } state_e;

endpackage

// File: rtl/vga_textram_if.sv
// Bus bundle between a text-RAM user (CPU/blitter side, master) and vga_textram (slave).
// Latency: wr_ack and rd_data arrive one cycle after the request; fills report busy/done.
// Backpressure: busy=1 means writes are dropped and commands ignored (no wr_ack).
// Signals: wr_en/wr_addr/wr_data/wr_ack write port, rd_addr/rd_data read port,
//          cmd_clear/cmd_scroll/fill_data commands, busy/done/scroll_row status.
interface vga_textram_if
  import vga_textram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned D      = DEF_CHAR_W + DEF_ATTR_W,
  parameter int unsigned SR_W   = $clog2(DEF_N_ROWS)
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [D-1:0]      wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [D-1:0]      rd_data;
  logic              cmd_clear;
  logic              cmd_scroll;
  logic [D-1:0]      fill_data;
  logic              busy;
  logic              done;
  logic [SR_W-1:0]   scroll_row;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, cmd_clear, cmd_scroll, fill_data,
    input  wr_ack, rd_data, busy, done, scroll_row
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, cmd_clear, cmd_scroll, fill_data,
    output wr_ack, rd_data, busy, done, scroll_row
  );

endinterface

// File: rtl/vga_textram_mem.sv
// Simple dual-port RAM (one write port, one registered read port) holding the character cells.
// Latency: read data valid one cycle after raddr_i; read-during-write to one address returns old data.
// Backpressure: none; every cycle accepts one write and one read.
// Ports: clk, we_i/waddr_i/wdata_i write port, raddr_i/rdata_o read port. Contents are not reset.
module vga_textram_mem
  import vga_textram_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_N_COLS * DEF_N_ROWS,
  parameter int unsigned D      = DEF_CHAR_W + DEF_ATTR_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [D-1:0]      wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [D-1:0]      rdata_o
);

  logic [D-1:0] mem_q [DEPTH];
  logic [D-1:0] rdata_q;

  // No reset on purpose so the array maps onto block RAM; the read sees the
  // pre-write value because both updates are non-blocking on the same edge.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_textram.sv
// Scrollable text-mode RAM: logical->physical translation, user/fill-engine write arbitration, clear/scroll FSM.
// Latency: wr_ack and rd_data one cycle after request; clear takes N_ENT cycles, scroll N_COLS cycles.
// Backpressure: while busy, user writes are dropped (no wr_ack) and new commands ignored; reads always served.
// Ports: clk, rst_n (async active-low), bus (vga_textram_if.slave).
module vga_textram
  import vga_textram_pkg::*;
#(
  parameter int unsigned N_COLS = DEF_N_COLS,
  parameter int unsigned N_ROWS = DEF_N_ROWS,
  parameter int unsigned CHAR_W = DEF_CHAR_W,
  parameter int unsigned ATTR_W = DEF_ATTR_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_textram_if.slave bus
);

  localparam int unsigned D     = CHAR_W + ATTR_W;
  localparam int unsigned N_ENT = N_COLS * N_ROWS;
  localparam int unsigned SR_W  = $clog2(N_ROWS);
  localparam logic [ADDR_W:0] N_ENT_V = (ADDR_W+1)'(N_ENT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, end_q;
  logic [D-1:0]      fill_q;
  logic [SR_W-1:0]   scroll_row_q;
  logic              done_q, wr_ack_q, rd_ok_q;

  logic              busy, eng_we, fill_last;
  logic              usr_we, rd_ok;
  logic [ADDR_W:0]   base;
  logic [ADDR_W-1:0] wr_phys, rd_phys;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [D-1:0]      mem_wdata, mem_rdata;

  // Logical row 0 lives at physical row scroll_row; rotate by that many cells.
  function automatic logic [ADDR_W-1:0] to_phys(input logic [ADDR_W-1:0] la,
                                               input logic [ADDR_W:0]   off);
    logic [ADDR_W:0] sum;
    sum = {1'b0, la} + off;
    if (sum >= N_ENT_V) sum = sum - N_ENT_V;
    return sum[ADDR_W-1:0];
  endfunction

  assign base      = (ADDR_W+1)'(32'(scroll_row_q) * N_COLS);
  assign fill_last = (ptr_q == end_q);

  assign usr_we  = bus.wr_en && !busy && ({1'b0, bus.wr_addr} < N_ENT_V);
  assign wr_phys = to_phys(bus.wr_addr, base);
  assign rd_ok   = ({1'b0, bus.rd_addr} < N_ENT_V);
  // Out-of-range reads are parked on cell 0 and masked at the output.
  assign rd_phys = rd_ok ? to_phys(bus.rd_addr, base) : '0;

  // Engine owns the write port whenever it runs; user writes are only taken when idle.
  assign mem_we    = eng_we | usr_we;
  assign mem_waddr = eng_we ? ptr_q  : wr_phys;
  assign mem_wdata = eng_we ? fill_q : bus.wr_data;

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. Clear has priority over scroll; commands only seen in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_clear)       state_d = ST_CLEAR;
        else if (bus.cmd_scroll) state_d = ST_SCROLL;
      end
      ST_CLEAR, ST_SCROLL: begin
        if (fill_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    busy   = 1'b0;
    eng_we = 1'b0;
    unique case (state_q)
      ST_CLEAR, ST_SCROLL: begin
        busy   = 1'b1;
        eng_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Engine datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      end_q        <= '0;
      fill_q       <= '0;
      scroll_row_q <= '0;
      done_q       <= 1'b0;
      wr_ack_q     <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      done_q   <= eng_we && fill_last;
      wr_ack_q <= usr_we;
      rd_ok_q  <= rd_ok;
      if (state_q == ST_IDLE) begin
        if (bus.cmd_clear) begin
          ptr_q        <= '0;
          end_q        <= ADDR_W'(N_ENT - 1);
          fill_q       <= bus.fill_data;
          scroll_row_q <= '0;
        end else if (bus.cmd_scroll) begin
          // The old top row becomes the new bottom row, so blank it in place.
          ptr_q        <= base[ADDR_W-1:0];
          end_q        <= base[ADDR_W-1:0] + ADDR_W'(N_COLS - 1);
          fill_q       <= bus.fill_data;
          scroll_row_q <= (scroll_row_q == SR_W'(N_ROWS - 1)) ? '0 : scroll_row_q + SR_W'(1);
        end
      end else begin
        ptr_q <= ptr_q + ADDR_W'(1);
      end
    end
  end

  vga_textram_mem #(
    .DEPTH  (N_ENT),
    .D      (D),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (rd_phys),
    .rdata_o (mem_rdata)
  );

  assign bus.rd_data    = rd_ok_q ? mem_rdata : '0;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.scroll_row = scroll_row_q;

endmodule

// File: doc/vga_textram.md
VGA_TEXTRAM -- requirements
Module: vga_textram

Interface
REQ-001 SHALL have parameter N_COLS, default 80, characters per row.
REQ-002 SHALL have parameter N_ROWS, default 30, rows per screen.
REQ-003 SHALL have parameter CHAR_W, default 7, character code width.
REQ-004 SHALL have parameter ATTR_W, default 4, per-cell attribute width; D = CHAR_W+ATTR_W.
REQ-005 SHALL have parameter ADDR_W, default 12, logical address width; N_ENT = N_COLS*N_ROWS SHALL be at most 2^ADDR_W.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_addr  in  ADDR_W  logical write address, row*N_COLS+col.
REQ-010 wr_data  in  D  cell write data, {attr,char}.
REQ-011 wr_ack  out  1  write-accepted pulse.
REQ-012 rd_addr  in  ADDR_W  logical read address, blitter side.
REQ-013 rd_data  out  D  registered read data.
REQ-014 cmd_clear  in  1  start a full-screen fill.
REQ-015 cmd_scroll  in  1  scroll up one row and blank the new bottom row.
REQ-016 fill_data  in  D  fill value, sampled with a command.
REQ-017 busy  out  1  fill engine active.
REQ-018 done  out  1  one-cycle fill-complete pulse.
REQ-019 scroll_row  out  clog2(N_ROWS)  current physical row of logical row 0.

Function
REQ-020 Physical address SHALL be logical + scroll_row*N_COLS, minus N_ENT if the sum is >= N_ENT, on both ports.
REQ-021 A write SHALL be accepted when wr_en=1, busy=0 and wr_addr<N_ENT; wr_ack=1 in the following cycle, otherwise 0.
REQ-022 Writes that are not accepted SHALL be dropped with no memory change.
REQ-023 rd_data SHALL update one cycle after rd_addr; it SHALL return 0 for rd_addr>=N_ENT.
REQ-024 A read to the same physical address as a write in the same cycle SHALL return the old data.
REQ-025 Reads SHALL be serviced during busy and return current memory contents.
REQ-026 The FSM SHALL have the states IDLE, CLEAR and SCROLL; in IDLE, busy=0.
REQ-027 In IDLE, cmd_clear SHALL enter CLEAR, latch fill_data, set ptr=0 and set scroll_row=0 on the next edge.
REQ-028 In IDLE, cmd_scroll SHALL enter SCROLL, latch fill_data, set ptr=old scroll_row*N_COLS and set scroll_row=(old+1) mod N_ROWS.
REQ-029 When cmd_clear and cmd_scroll are asserted together, cmd_clear SHALL win and cmd_scroll SHALL be discarded.
REQ-030 Commands received while busy=1 SHALL be ignored.
REQ-031 The engine SHALL write the latched fill data at ptr once per cycle and increment ptr; CLEAR SHALL write N_ENT cells and SCROLL SHALL write N_COLS cells.
REQ-032 For a command sampled at edge k: busy=1 from k+1, first write at k+1, last write at k+L, done=1 and busy=0 at k+L+1, then IDLE.
REQ-033 Engine writes SHALL use physical addresses and bypass REQ-020.

Reset
REQ-034 On rst_n=0: state=IDLE, busy=0, done=0, wr_ack=0, rd_data=0, scroll_row=0, ptr=0.
REQ-035 Memory contents SHALL NOT be reset.
REQ-036 A reset during a fill SHALL abort it with no done pulse.

Structure
REQ-037 Package vga_textram_pkg SHALL hold the FSM state encoding and the default geometry constants.
REQ-038 Storage SHALL be the sub-module vga_textram_mem: a simple dual-port RAM of N_ENT x D with one write port and a registered read port, inferable as block RAM.
REQ-039 Address translation, arbitration and the FSM SHALL live in vga_textram.

Verification
REQ-040 Write 0x5A1 at logical 0, then read it -> wr_ack the next cycle; rd_data=0x5A1 one cycle after rd_addr=0.
REQ-041 cmd_clear with fill_data=0x020 -> busy held for exactly 2400 cycles, done pulse; all 2400 cells read 0x020; scroll_row=0.
REQ-042 After a clear, write row 1 col 0=0x041, then cmd_scroll with fill_data=0 -> scroll_row=1, busy for 80 cycles; logical 0 reads 0x041; logical 2320..2399 read 0.
REQ-043 Apply 30 scrolls -> scroll_row wraps 29->0; the logical-to-physical mapping returns to identity.
REQ-044 wr_en during busy, wr_addr=2400, and simultaneous cmd_clear+cmd_scroll -> no wr_ack and no memory change; clear only, scroll_row=0.
REQ-045 Deassert rst_n at cycle 100 of a clear -> busy=0 immediately, no done; a subsequent cmd_clear completes normally.
